// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: state encoding,
// default widths and the alignment mask used to detect odd byte addresses.
package mem_stage_pkg;

   localparam int DEF_DW = 16;
   localparam int DEF_RW = 3;
   localparam logic [15:0] ALIGN_MASK = 16'h0001;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      REQ    = 2'b01,
      WAIT   = 2'b10,
      HALTED = 2'b11
   } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundles the execute-side handshake, the data-memory port and the writeback
// bundle of the memory-access stage; slave is the stage, master its environment.
interface mem_access_stage_if import mem_stage_pkg::*; #(
   parameter int DW = DEF_DW,
   parameter int RW = DEF_RW
);

   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [DW-1:0] in_alu_out;
   logic [DW-1:0] in_st_data;
   logic          in_mem_rd;
   logic          in_mem_wr;
   logic          in_wr_en;
   logic [RW-1:0] in_wr_reg;
   logic          in_halt;

   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;

   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_wr_en;
   logic [RW-1:0] out_wr_reg;
   logic          out_halt;
   logic          out_err;

   modport slave (
      input  in_valid, flush, in_alu_out, in_st_data, in_mem_rd, in_mem_wr,
             in_wr_en, in_wr_reg, in_halt, mem_rdata, mem_done,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
             out_valid, out_data, out_wr_en, out_wr_reg, out_halt, out_err
   );

   modport master (
      output in_valid, flush, in_alu_out, in_st_data, in_mem_rd, in_mem_wr,
             in_wr_en, in_wr_reg, in_halt, mem_rdata, mem_done,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
             out_valid, out_data, out_wr_en, out_wr_reg, out_halt, out_err
   );

endinterface

// File: rtl/mem_access_stage_stage_reg.sv
// Width-parameterised pipeline register with load enable and asynchronous
// active-low clear to zero.
module stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_o <= '0;
      else if (en_i)
         q_o <= d_i;
   end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM stage: registers execute results, sequences loads/stores over a
// req/done memory handshake and emits a one-cycle writeback bundle.
module mem_access_stage import mem_stage_pkg::*; #(
   parameter int DW = DEF_DW,
   parameter int RW = DEF_RW
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_access_stage_if.slave  bus
);

   localparam int REQ_W = 2 * DW + 3 + RW;

   state_t        state_q, state_d;
   logic          accept, isMem, misaligned, captureReq, complete, memActive;
   logic [DW-1:0] reqAddr_q, reqWdata_q;
   logic          reqWe_q, reqLoad_q, reqWrEn_q;
   logic [RW-1:0] reqWrReg_q;
   logic [DW-1:0] wbData_d;
   logic [RW-1:0] wbWrReg_d;
   logic          wbValid_d, wbWrEn_d, wbHalt_d, wbErr_d;

   assign accept     = bus.in_valid & (state_q == IDLE) & ~bus.flush;
   assign isMem      = bus.in_mem_rd | bus.in_mem_wr;
   assign misaligned = |(bus.in_alu_out & DW'(ALIGN_MASK));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // A set write flag wins over the read flag, so rd+wr behaves as a store.
   always_comb begin
      state_d    = state_q;
      captureReq = 1'b0;
      complete   = 1'b0;
      wbData_d   = bus.in_alu_out;
      wbWrReg_d  = bus.in_wr_reg;
      wbValid_d  = 1'b0;
      wbWrEn_d   = 1'b0;
      wbHalt_d   = 1'b0;
      wbErr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.in_halt) begin
                  complete  = 1'b1;
                  wbValid_d = 1'b1;
                  wbHalt_d  = 1'b1;
                  state_d   = HALTED;
               end else if (isMem && misaligned) begin
                  complete  = 1'b1;
                  wbValid_d = 1'b1;
                  wbErr_d   = 1'b1;
               end else if (isMem) begin
                  captureReq = 1'b1;
                  state_d    = REQ;
               end else begin
                  complete  = 1'b1;
                  wbValid_d = 1'b1;
                  wbWrEn_d  = bus.in_wr_en;
               end
            end
         end
         REQ: state_d = WAIT;
         WAIT: begin
            if (bus.mem_done) begin
               complete  = 1'b1;
               wbValid_d = 1'b1;
               wbWrEn_d  = reqLoad_q & reqWrEn_q;
               wbData_d  = reqLoad_q ? bus.mem_rdata : reqAddr_q;
               wbWrReg_d = reqWrReg_q;
               state_d   = IDLE;
            end
         end
         HALTED: state_d = HALTED;
      endcase
   end

   stage_reg #(.W(REQ_W)) u_reqReg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (captureReq),
      .d_i   ({bus.in_alu_out, bus.in_st_data, bus.in_mem_wr, ~bus.in_mem_wr,
               bus.in_wr_en, bus.in_wr_reg}),
      .q_o   ({reqAddr_q, reqWdata_q, reqWe_q, reqLoad_q, reqWrEn_q, reqWrReg_q})
   );

   // Data and destination hold between completions; the flag bits pulse.
   stage_reg #(.W(DW + RW)) u_wbHold (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (complete),
      .d_i   ({wbData_d, wbWrReg_d}),
      .q_o   ({bus.out_data, bus.out_wr_reg})
   );

   stage_reg #(.W(4)) u_wbPulse (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (1'b1),
      .d_i   ({wbValid_d, wbWrEn_d, wbHalt_d, wbErr_d}),
      .q_o   ({bus.out_valid, bus.out_wr_en, bus.out_halt, bus.out_err})
   );

   assign memActive     = (state_q == REQ) || (state_q == WAIT);
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.mem_req   = (state_q == REQ);
   assign bus.mem_we    = reqWe_q & memActive;
   assign bus.mem_addr  = reqAddr_q;
   assign bus.mem_wdata = reqWdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected
// writeback bundles; a monitor pops and compares on every out_valid.
module tb_mem_access_stage;
   import mem_stage_pkg::*;

   localparam int DW = 16;
   localparam int RW = 3;

   typedef struct {
      logic [DW-1:0] data;
      logic          chkData;
      logic          wrEn;
      logic [RW-1:0] wrReg;
      logic          halt;
      logic          err;
      int            cycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   exp_t expQ[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cycleCnt = 0;
   int   resetCount = 0;
   int   memLat = 1;
   int   reqCount = 0;
   logic lastWe = 1'b0;
   logic [DW-1:0] memArr [0:255];

   mem_access_stage_if #(.DW(DW), .RW(RW)) bus ();

   mem_access_stage #(.DW(DW), .RW(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   always @(negedge rst_n) resetCount <= resetCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input logic [DW-1:0] data, input logic chkData,
                          input logic wrEn, input logic [RW-1:0] wrReg,
                          input logic halt, input logic err, input int latency);
      expQ.push_back('{data, chkData, wrEn, wrReg, halt, err, cycleCnt + latency});
   endtask

   // Drives one offer at posedge+1 and returns at posedge+1 of the next cycle.
   task automatic applyStimulus(input logic valid, input logic flush,
                                input logic [DW-1:0] alu, input logic [DW-1:0] st,
                                input logic rd, input logic wr, input logic wrEn,
                                input logic [RW-1:0] wrReg, input logic halt);
      bus.in_valid   = valid;
      bus.flush      = flush;
      bus.in_alu_out = alu;
      bus.in_st_data = st;
      bus.in_mem_rd  = rd;
      bus.in_mem_wr  = wr;
      bus.in_wr_en   = wrEn;
      bus.in_wr_reg  = wrReg;
      bus.in_halt    = halt;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.in_halt  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitReady(output int low);
      low = 0;
      while (bus.in_ready !== 1'b1 && low < 50) begin
         low++;
         @(posedge clk);
         #1;
      end
      if (low >= 50)
         checkOutput("waitReady timeout", 32'd0, 32'd1);
   endtask

   // Monitor: every out_valid must match the oldest expected bundle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected out_valid", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("wb cycle", cycleCnt, e.cycle);
               if (e.chkData)
                  checkOutput("wb data", bus.out_data, e.data);
               checkOutput("wb wr_en", bus.out_wr_en, e.wrEn);
               checkOutput("wb wr_reg", bus.out_wr_reg, e.wrReg);
               checkOutput("wb halt", bus.out_halt, e.halt);
               checkOutput("wb err", bus.out_err, e.err);
            end
         end else begin
            checkOutput("idle pulses", {bus.out_wr_en, bus.out_halt, bus.out_err}, 3'b000);
         end
      end
   end

   // Memory model: answers a request memLat cycles later, checks request hold.
   initial begin
      logic [DW-1:0] a, w;
      logic          we;
      int            rc;
      logic          aborted;
      for (int i = 0; i < 256; i++) memArr[i] = '0;
      memArr[8'h20] = 16'hBEEF;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) begin
            reqCount++;
            a       = bus.mem_addr;
            w       = bus.mem_wdata;
            we      = bus.mem_we;
            lastWe  = we;
            rc      = resetCount;
            aborted = 1'b0;
            for (int i = 0; i < memLat; i++) begin
               @(negedge clk);
               if (resetCount != rc) begin
                  aborted = 1'b1;
                  break;
               end
               checkOutput("mem_req single cycle", bus.mem_req, 1'b0);
               checkOutput("mem_addr held", bus.mem_addr, a);
               checkOutput("mem_wdata held", bus.mem_wdata, w);
               checkOutput("mem_we held", bus.mem_we, we);
            end
            if (!aborted) begin
               if (we)
                  memArr[a[8:1]] = w;
               else
                  bus.mem_rdata = memArr[a[8:1]];
               bus.mem_done = 1'b1;
               @(negedge clk);
               bus.mem_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int low;
      int rb;
      bus.in_valid   = 1'b1;
      bus.flush      = 1'b0;
      bus.in_alu_out = 16'h00AA;
      bus.in_st_data = 16'h5555;
      bus.in_mem_rd  = 1'b0;
      bus.in_mem_wr  = 1'b0;
      bus.in_wr_en   = 1'b1;
      bus.in_wr_reg  = 3'd1;
      bus.in_halt    = 1'b0;

      // Reset with a valid instruction offered.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset out_valid", bus.out_valid, 1'b0);
      checkOutput("reset out_data", bus.out_data, 16'h0);
      checkOutput("reset out_wr_en", bus.out_wr_en, 1'b0);
      checkOutput("reset out_wr_reg", bus.out_wr_reg, 3'd0);
      checkOutput("reset out_halt", bus.out_halt, 1'b0);
      checkOutput("reset out_err", bus.out_err, 1'b0);
      checkOutput("reset mem_req", bus.mem_req, 1'b0);
      checkOutput("reset mem_we", bus.mem_we, 1'b0);
      checkOutput("reset mem_addr", bus.mem_addr, 16'h0);
      checkOutput("reset mem_wdata", bus.mem_wdata, 16'h0);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("in_ready after reset", bus.in_ready, 1'b1);

      // Back-to-back ALU ops.
      for (int i = 1; i <= 3; i++) begin
         checkOutput("alu in_ready", bus.in_ready, 1'b1);
         pushExp(DW'(i), 1'b1, 1'b1, RW'(i), 1'b0, 1'b0, 1);
         applyStimulus(1'b1, 1'b0, DW'(i), 16'h0, 1'b0, 1'b0, 1'b1, RW'(i), 1'b0);
      end
      idleCycles(2);

      // Aligned load, memory answers 3 cycles after the request.
      memLat = 3;
      rb     = reqCount;
      pushExp(16'hBEEF, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
      bus.in_valid = 1'b0;
      waitReady(low);
      checkOutput("load stall cycles", low, 4);
      checkOutput("load request count", reqCount, rb + 1);
      checkOutput("load mem_we", lastWe, 1'b0);
      idleCycles(1);

      // Store (rd and wr both set) with a flushed offer during and after it.
      memLat = 4;
      pushExp(16'h0010, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 6);
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h1234, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0);
      bus.flush      = 1'b1;
      bus.in_alu_out = 16'h0777;
      bus.in_mem_rd  = 1'b0;
      bus.in_mem_wr  = 1'b0;
      bus.in_wr_reg  = 3'd6;
      waitReady(low);
      checkOutput("store stall cycles", low, 5);
      @(posedge clk);
      #1;
      idleCycles(2);
      checkOutput("store mem_we", lastWe, 1'b1);
      checkOutput("store data written", memArr[8], 16'h1234);

      // Misaligned load: error bundle, no memory request.
      rb = reqCount;
      pushExp(16'h0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 16'h0021, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
      checkOutput("misaligned in_ready", bus.in_ready, 1'b1);
      idleCycles(3);
      checkOutput("misaligned no request", reqCount, rb);

      // Reset pulsed while waiting on memory: no completion reported.
      memLat = 6;
      applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid reset mem_req", bus.mem_req, 1'b0);
      checkOutput("mid reset mem_we", bus.mem_we, 1'b0);
      checkOutput("mid reset mem_addr", bus.mem_addr, 16'h0);
      checkOutput("mid reset out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      checkOutput("in_ready after mid reset", bus.in_ready, 1'b1);
      idleCycles(10);

      // HALT, then the stage refuses everything.
      rb = reqCount;
      pushExp(16'h0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
      for (int i = 0; i < 10; i++) begin
         checkOutput("halted in_ready", bus.in_ready, 1'b0);
         applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
      end
      idleCycles(2);
      checkOutput("halted no request", reqCount, rb);
      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of execute. Registers execute results (EX/MEM boundary) and sequences loads/stores to a multi-cycle data memory over a req/done handshake.
- Stalls upstream while a memory transaction is outstanding.
- Presents a one-cycle-valid writeback bundle to the writeback stage.

Parameters:
- DW, 16, datapath/address width in bits.
- RW, 3, register-specifier width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  execute presents an instruction this cycle.
- in_ready  out  1  stage accepts this cycle; upstream holds its outputs when low.
- flush  in  1  squash the instruction offered this cycle.
- in_alu_out  in  DW  ALU result; memory address for loads and stores.
- in_st_data  in  DW  store data (operand 2 path).
- in_mem_rd  in  1  instruction is a load.
- in_mem_wr  in  1  instruction is a store.
- in_wr_en  in  1  instruction writes the register file.
- in_wr_reg  in  RW  destination register.
- in_halt  in  1  instruction is HALT.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  DW  word-aligned byte address; valid with mem_req.
- mem_wdata  out  DW  store data; valid with mem_req.
- mem_rdata  in  DW  read data; valid with mem_done.
- mem_done  in  1  transaction complete.
- out_valid  out  1  writeback bundle valid (one cycle per instruction).
- out_data  out  DW  load data, or ALU result for non-loads.
- out_wr_en  out  1  register write enable; 0 whenever out_valid = 0.
- out_wr_reg  out  RW  destination register.
- out_halt  out  1  HALT reached writeback.
- out_err  out  1  misaligned access detected for this instruction.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE; all out_* = 0; mem_req = mem_we = 0; mem_addr = mem_wdata = 0. in_ready = 1 after release.
- States:
  - IDLE: in_ready = 1.
  - REQ: mem_req = 1 for exactly one cycle.
  - WAIT: waiting on mem_done.
  - HALTED: terminal.
  - in_ready = 0 in REQ, WAIT and HALTED.
- Accept = in_valid & in_ready & ~flush. A flushed or invalid cycle changes nothing; out_valid = 0 next cycle.
- Non-memory op accepted in IDLE:
  - Next cycle: out_valid = 1, out_data = in_alu_out, wr fields copied.
  - Latency 1; throughput 1 per cycle.
- in_mem_rd and in_mem_wr both set: treated as a store.
- Memory op accepted with in_alu_out[0] = 1 (misaligned):
  - No request is issued.
  - Next cycle: out_valid = 1, out_err = 1, out_wr_en = 0.
  - Stays in IDLE.
- Aligned memory op accepted: address, store data and controls are registered; next state is REQ.
  - REQ: mem_req = 1 with mem_addr, mem_we and mem_wdata driven; next state is WAIT.
  - mem_done is ignored in REQ. The earliest honoured mem_done is the first WAIT cycle.
  - WAIT: hold mem_addr, mem_we and mem_wdata stable; mem_req = 0.
  - On mem_done: load captures mem_rdata into out_data; next state is IDLE; out_valid = 1 the following cycle.
  - Store: out_wr_en = 0 and out_data = address.
  - Load latency = N + 2 cycles, where mem_done arrives N cycles after the REQ cycle (N ≥ 1).
- flush during REQ/WAIT: no effect. The outstanding transaction completes; flush applies only to the offered instruction.
- HALT accepted:
  - Next cycle: out_valid = 1, out_halt = 1, out_wr_en = 0; state = HALTED.
  - in_ready = 0 until reset; no further requests.
- out_valid is a pulse. When no instruction completes, out_valid = out_wr_en = out_halt = out_err = 0. out_data and out_wr_reg hold their last values.
- rst_n asserted mid-transaction: immediate return to IDLE, mem_req = 0, no completion reported. The memory model is reset by the same rst_n.
- Spurious mem_done in IDLE/HALTED: ignored.

Decomposition:
- Shared package mem_stage_pkg: state encoding (IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10, HALTED = 2'b11), DW/RW defaults, ALIGN_MASK = 16'h0001.
- One sub-module, stage_reg: width-parameterised register with enable and async active-low clear. Instantiated for the captured request fields and for the writeback bundle.
- FSM and output muxing live in mem_access_stage.

Test Plan:
- Reset: rst_n low with in_valid = 1 → all out_* = 0, mem_req = 0. After release, in_ready = 1.
- ALU stream: 3 back-to-back non-memory ops with alu_out 16'h0001, 16'h0002, 16'h0003, wr_reg 1, 2, 3 → out_valid on 3 consecutive cycles; data 1, 2, 3; out_wr_en = 1; in_ready never low.
- Load, N = 3: addr 16'h0040, memory returns 16'hBEEF → mem_req high exactly 1 cycle with mem_we = 0; in_ready low for 4 cycles; out_valid with out_data = 16'hBEEF 5 cycles after accept.
- Store + flush: store of 16'h1234 to 16'h0010, then flush asserted during WAIT → mem_we = 1, wdata = 16'h1234 held until done; transaction completes; out_wr_en = 0. The instruction offered with flush is dropped (no out_valid for it).
- Misaligned load: addr 16'h0021 → mem_req never asserts; next cycle out_valid = 1, out_err = 1, out_wr_en = 0.
- Halt / reset mid-operation: HALT → out_halt pulse, then in_ready = 0 for 10 cycles. Separately, rst_n pulsed during WAIT → state IDLE, no out_valid, mem_req = 0.
